// File: rtl/subleq_sequencer_pkg.sv
// Shared SUBLEQ definitions: default word width, halt address and FSM state encoding.
// Pure declarations, no logic; imported by the sequencer and its ALU.
package subleq_sequencer_pkg;

  localparam int WORD_SIZE_DEF = 8;
  localparam int HALT_ADDR_DEF = 255;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_FETCH_A = 4'd1,
    ST_FETCH_B = 4'd2,
    ST_FETCH_C = 4'd3,
    ST_READ_A  = 4'd4,
    ST_READ_B  = 4'd5,
    ST_WRITE   = 4'd6,
    ST_HALT    = 4'd7,
    ST_WAIT    = 4'd8
  } state_t;

endpackage

// File: rtl/subleq_alu.sv
// SUBLEQ arithmetic: diff = vb - va, branch taken when diff <= 0 (signed), next pc select.
// Purely combinational, zero latency, no flow control.
module subleq_alu #(
  parameter int WORD_SIZE = 8
) (
  input  logic [WORD_SIZE-1:0] va,
  input  logic [WORD_SIZE-1:0] vb,
  input  logic [WORD_SIZE-1:0] pc,
  input  logic [WORD_SIZE-1:0] c,
  output logic [WORD_SIZE-1:0] diff,
  output logic                 taken,
  output logic [WORD_SIZE-1:0] next_pc
);

  assign diff    = vb - va;
  assign taken   = (diff == '0) || diff[WORD_SIZE-1];
  assign next_pc = taken ? c : pc + WORD_SIZE'(3);

endmodule

// File: rtl/subleq_sequencer.sv
// SUBLEQ engine owning all memory traffic: 6 cycles/instruction (7 with SUBLEQ_STEP_EN, gated by step in WAIT).
// Outputs are registered, so each state's strobes/address are prepared on the edge entering that state.
module subleq_sequencer
  import subleq_sequencer_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int HALT_ADDR = HALT_ADDR_DEF
) (
  input  logic                 clk,
  input  logic                 areset_n,
`ifdef SUBLEQ_STEP_EN
  input  logic                 step,
`endif
  output logic                 load,
  output logic                 store,
  output logic [WORD_SIZE-1:0] addr,
  output logic [WORD_SIZE-1:0] mem_in,
  input  logic [WORD_SIZE-1:0] mem_out,
  output logic [WORD_SIZE-1:0] pc,
  output logic                 halted,
  output logic                 instr_done
);

  localparam logic [WORD_SIZE-1:0] HALT_A = WORD_SIZE'(HALT_ADDR);

  state_t               r_state;
  logic [WORD_SIZE-1:0] r_pc, r_a, r_b, r_c, r_va, r_vb;
  logic                 r_load, r_store, r_halted, r_done;
  logic [WORD_SIZE-1:0] r_addr, r_mem_in;

  logic [WORD_SIZE-1:0] w_alu_vb, w_diff, w_next_pc;
  logic                 w_taken, w_halt;

  // In READ_B the B operand is still on mem_out, so diff is ready to register as WRITE's mem_in.
  assign w_alu_vb = (r_state == ST_READ_B) ? mem_out : r_vb;
  assign w_halt   = w_taken && (r_c == HALT_A);

  subleq_alu #(.WORD_SIZE(WORD_SIZE)) u_alu (
    .va      (r_va),
    .vb      (w_alu_vb),
    .pc      (r_pc),
    .c       (r_c),
    .diff    (w_diff),
    .taken   (w_taken),
    .next_pc (w_next_pc)
  );

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_state  <= ST_IDLE;
      r_pc     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_va     <= '0;
      r_vb     <= '0;
      r_load   <= 1'b0;
      r_store  <= 1'b0;
      r_addr   <= '0;
      r_mem_in <= '0;
      r_halted <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_load   <= 1'b0;
      r_store  <= 1'b0;
      r_addr   <= '0;
      r_mem_in <= '0;
      r_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
`ifdef SUBLEQ_STEP_EN
          r_state <= ST_WAIT;
`else
          r_state <= ST_FETCH_A;
          r_load  <= 1'b1;
          r_addr  <= r_pc;
`endif
        end
`ifdef SUBLEQ_STEP_EN
        ST_WAIT: begin
          if (step) begin
            r_state <= ST_FETCH_A;
            r_load  <= 1'b1;
            r_addr  <= r_pc;
          end
        end
`endif
        ST_FETCH_A: begin
          r_a     <= mem_out;
          r_state <= ST_FETCH_B;
          r_load  <= 1'b1;
          r_addr  <= r_pc + WORD_SIZE'(1);
        end
        ST_FETCH_B: begin
          r_b     <= mem_out;
          r_state <= ST_FETCH_C;
          r_load  <= 1'b1;
          r_addr  <= r_pc + WORD_SIZE'(2);
        end
        ST_FETCH_C: begin
          r_c     <= mem_out;
          r_state <= ST_READ_A;
          r_load  <= 1'b1;
          r_addr  <= r_a;
        end
        ST_READ_A: begin
          r_va    <= mem_out;
          r_state <= ST_READ_B;
          r_load  <= 1'b1;
          r_addr  <= r_b;
        end
        ST_READ_B: begin
          r_vb     <= mem_out;
          r_state  <= ST_WRITE;
          r_store  <= 1'b1;
          r_addr   <= r_b;
          r_mem_in <= w_diff;
          r_done   <= 1'b1;
        end
        ST_WRITE: begin
          r_pc <= w_next_pc;
          if (w_halt) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else begin
`ifdef SUBLEQ_STEP_EN
            r_state <= ST_WAIT;
`else
            r_state <= ST_FETCH_A;
            r_load  <= 1'b1;
            r_addr  <= w_next_pc;
`endif
          end
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign load       = r_load;
  assign store      = r_store;
  assign addr       = r_addr;
  assign mem_in     = r_mem_in;
  assign pc         = r_pc;
  assign halted     = r_halted;
  assign instr_done = r_done;

endmodule

// File: tb/tb_subleq_sequencer.sv
// Bench for subleq_sequencer: directed scenarios plus random programs against a SUBLEQ interpreter.
module tb_subleq_sequencer;

`ifdef SUBLEQ_STEP_EN
  localparam int CPI = 7;
`else
  localparam int CPI = 6;
`endif

  logic       clk = 1'b0;
  logic       areset_n = 1'b1;
  logic       load, store, halted, instr_done;
  logic [7:0] addr, mem_in, mem_out, pc;
  logic [7:0] mem [256];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
`ifdef SUBLEQ_STEP_EN
  logic       step = 1'b1;
`endif

  always #5 clk = ~clk;

  assign mem_out = load ? mem[addr] : 8'h00;

  subleq_sequencer dut (
    .clk        (clk),
    .areset_n   (areset_n),
`ifdef SUBLEQ_STEP_EN
    .step       (step),
`endif
    .load       (load),
    .store      (store),
    .addr       (addr),
    .mem_in     (mem_in),
    .mem_out    (mem_out),
    .pc         (pc),
    .halted     (halted),
    .instr_done (instr_done)
  );

  // One clock: commit the store seen this cycle at the edge, then land on the next negedge.
  task automatic tick();
    logic       st;
    logic [7:0] ad, da;
    st = store; ad = addr; da = mem_in;
    @(posedge clk);
    if (st) mem[ad] = da;
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  // Reset, release on a negedge; the released cycle is cycle 1 (IDLE).
  task automatic restart();
    @(negedge clk);
    areset_n = 1'b0;
    @(negedge clk);
    areset_n = 1'b1;
    cyc = 1;
  endtask

  task automatic test_reset();
    #1 areset_n = 1'b0;
    #1;
    total++; if (load !== 1'b0 || store !== 1'b0) begin bad++; $display("FAIL reset_strobes got=%b%b want=00", load, store); end
    total++; if (addr !== 8'h00 || mem_in !== 8'h00) begin bad++; $display("FAIL reset_bus got=%h/%h want=00/00", addr, mem_in); end
    total++; if (pc !== 8'h00) begin bad++; $display("FAIL reset_pc got=%h want=00", pc); end
    total++; if (halted !== 1'b0 || instr_done !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", halted, instr_done); end
    repeat (2) @(posedge clk);
    #1;
    total++; if (load !== 1'b0 || pc !== 8'h00) begin bad++; $display("FAIL reset_held got=%b/%h want=0/00", load, pc); end
  endtask

  task automatic test_not_taken();
    logic [7:0] ex [5];
    clear_mem();
    mem[0] = 8'd3; mem[1] = 8'd4; mem[2] = 8'd9; mem[3] = 8'd5; mem[4] = 8'd7;
    ex[0] = 8'd0; ex[1] = 8'd1; ex[2] = 8'd2; ex[3] = 8'd3; ex[4] = 8'd4;
    restart();
    total++; if (load !== 1'b0 || store !== 1'b0 || addr !== 8'h00) begin bad++; $display("FAIL nt_idle got=%b%b/%h want=00/00", load, store, addr); end
    while (cyc < CPI - 4) tick();
    for (int k = 0; k < 5; k++) begin
      total++; if (load !== 1'b1 || store !== 1'b0 || addr !== ex[k]) begin bad++; $display("FAIL nt_fetch%0d got=%b%b/%0d want=10/%0d", k, load, store, addr, ex[k]); end
      tick();
    end
    total++; if (cyc !== 1 + CPI || store !== 1'b1 || load !== 1'b0) begin bad++; $display("FAIL nt_store cyc=%0d got=%b%b want=01 at %0d", cyc, load, store, 1 + CPI); end
    total++; if (addr !== 8'd4 || mem_in !== 8'd2) begin bad++; $display("FAIL nt_wdata got=%0d/%0d want=4/2", addr, mem_in); end
    total++; if (instr_done !== 1'b1) begin bad++; $display("FAIL nt_done got=%b want=1", instr_done); end
    tick();
    total++; if (pc !== 8'd3 || mem[4] !== 8'd2) begin bad++; $display("FAIL nt_pc got=%0d/%0d want=3/2", pc, mem[4]); end
    total++; if (instr_done !== 1'b0 || mem_in !== 8'h00) begin bad++; $display("FAIL nt_after got=%b/%h want=0/00", instr_done, mem_in); end
  endtask

  task automatic test_taken();
    int n = 0;
    clear_mem();
    mem[0] = 8'd3; mem[1] = 8'd4; mem[2] = 8'd9; mem[3] = 8'd7; mem[4] = 8'd5;
    restart();
    while (cyc <= 4 * CPI + 2) begin
      if (instr_done) begin
        n++;
        total++; if ((cyc - 1) % CPI != 0) begin bad++; $display("FAIL tk_done_phase got=cycle%0d want=multiple of %0d plus 1", cyc, CPI); end
      end
      if (cyc == 1 + CPI) begin
        total++; if (store !== 1'b1 || mem_in !== 8'hFE) begin bad++; $display("FAIL tk_wdata got=%b/%h want=1/fe", store, mem_in); end
      end
      if (cyc == 2 + CPI) begin
        total++; if (pc !== 8'd9) begin bad++; $display("FAIL tk_pc got=%0d want=9", pc); end
      end
      tick();
    end
    total++; if (n != 4) begin bad++; $display("FAIL tk_done_count got=%0d want=4", n); end
  endtask

  task automatic test_halt();
    clear_mem();
    mem[0] = 8'd3; mem[1] = 8'd3; mem[2] = 8'd255; mem[3] = 8'h5A;
    restart();
    while (cyc < 1 + CPI) tick();
    total++; if (store !== 1'b1 || addr !== 8'd3 || mem_in !== 8'h00) begin bad++; $display("FAIL ht_store got=%b/%0d/%h want=1/3/00", store, addr, mem_in); end
    tick();
    total++; if (halted !== 1'b1 || pc !== 8'd255 || mem[3] !== 8'h00) begin bad++; $display("FAIL ht_enter got=%b/%0d/%h want=1/255/00", halted, pc, mem[3]); end
    for (int k = 0; k < 20; k++) begin
      tick();
      total++; if (load !== 1'b0 || store !== 1'b0 || addr !== 8'h00 || halted !== 1'b1) begin bad++; $display("FAIL ht_hold%0d got=%b%b/%h/%b want=00/00/1", k, load, store, addr, halted); end
    end
  endtask

  task automatic test_wrap();
    int w2;
    clear_mem();
    mem[0] = 8'd10; mem[1] = 8'd10; mem[2] = 8'd253;
    mem[253] = 8'd20; mem[254] = 8'd21; mem[255] = 8'd7;
    mem[20] = 8'd1; mem[21] = 8'd5;
    w2 = 1 + 2 * CPI;
    restart();
    while (cyc < w2 - 5) tick();
    for (int k = 0; k < 3; k++) begin
      total++; if (load !== 1'b1 || addr !== 8'(253 + k)) begin bad++; $display("FAIL wr_fetch%0d got=%b/%0d want=1/%0d", k, load, addr, 253 + k); end
      tick();
    end
    while (cyc < w2) tick();
    total++; if (store !== 1'b1 || addr !== 8'd21 || mem_in !== 8'd4) begin bad++; $display("FAIL wr_store got=%b/%0d/%0d want=1/21/4", store, addr, mem_in); end
    tick();
    total++; if (pc !== 8'd0 || halted !== 1'b0) begin bad++; $display("FAIL wr_pc got=%0d/%b want=0/0", pc, halted); end
  endtask

  task automatic test_reset_mid_write();
    logic st;
    clear_mem();
    mem[0] = 8'd3; mem[1] = 8'd4; mem[2] = 8'd9; mem[3] = 8'd5; mem[4] = 8'd7;
    restart();
    while (cyc < 1 + CPI) tick();
    total++; if (store !== 1'b1) begin bad++; $display("FAIL rm_pre got=%b want=1", store); end
    #1 areset_n = 1'b0;
    #1;
    total++; if (store !== 1'b0 || load !== 1'b0 || addr !== 8'h00 || mem_in !== 8'h00 || instr_done !== 1'b0) begin bad++; $display("FAIL rm_drop got=%b%b/%h/%h/%b want=00/00/00/0", load, store, addr, mem_in, instr_done); end
    #2 st = store;
    @(posedge clk);
    if (st) mem[4] = mem_in;
    @(negedge clk);
    total++; if (mem[4] !== 8'd7) begin bad++; $display("FAIL rm_mem got=%0d want=7", mem[4]); end
    areset_n = 1'b1;
    cyc = 1;
    total++; if (pc !== 8'd0 || load !== 1'b0) begin bad++; $display("FAIL rm_idle got=%0d/%b want=0/0", pc, load); end
    while (cyc < CPI - 4) tick();
    total++; if (load !== 1'b1 || addr !== 8'd0) begin bad++; $display("FAIL rm_refetch got=%b/%0d want=1/0", load, addr); end
  endtask

  // Random programs compared against a plain instruction-level SUBLEQ interpreter.
  task automatic test_random();
    logic [7:0] m [256];
    logic [7:0] pcm, a, b, c, d, p1, p2, ea;
    logic [7:0] qa [$];
    logic [7:0] qd [$];
    logic [7:0] qp [$];
    logic       halt_m;
    int         n, errs;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 256; i++) begin
        m[i] = 8'($urandom);
        mem[i] = m[i];
      end
      qa.delete(); qd.delete(); qp.delete();
      pcm = 8'd0; halt_m = 1'b0; n = 0;
      while (n < 15 && !halt_m) begin
        p1 = pcm + 8'd1; p2 = pcm + 8'd2;
        a = m[pcm]; b = m[p1]; c = m[p2];
        d = m[b] - m[a];
        m[b] = d;
        qa.push_back(b); qd.push_back(d);
        if ($signed(d) <= 0) begin
          pcm = c;
          if (c == 8'd255) halt_m = 1'b1;
        end else begin
          pcm = pcm + 8'd3;
        end
        qp.push_back(pcm);
        n++;
      end
      restart();
      while (cyc <= n * CPI + 3) begin
        total++; if (load && store) begin bad++; $display("FAIL rnd%0d_both cyc=%0d got=11 want=not both", it, cyc); end
        if (store) begin
          if (qa.size() == 0) begin
            total++; bad++; $display("FAIL rnd%0d_extra_store cyc=%0d got=store want=none", it, cyc);
            tick();
          end else begin
            ea = qa.pop_front();
            total++; if (addr !== ea) begin bad++; $display("FAIL rnd%0d_addr got=%0d want=%0d", it, addr, ea); end
            ea = qd.pop_front();
            total++; if (mem_in !== ea) begin bad++; $display("FAIL rnd%0d_data got=%h want=%h", it, mem_in, ea); end
            tick();
            ea = qp.pop_front();
            total++; if (pc !== ea) begin bad++; $display("FAIL rnd%0d_pc got=%0d want=%0d", it, pc, ea); end
          end
        end else begin
          tick();
        end
      end
      total++; if (qa.size() != 0) begin bad++; $display("FAIL rnd%0d_missing got=%0d left want=0", it, qa.size()); end
      total++; if (halted !== halt_m) begin bad++; $display("FAIL rnd%0d_halted got=%b want=%b", it, halted, halt_m); end
      errs = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== m[i]) errs++;
      total++; if (errs != 0) begin bad++; $display("FAIL rnd%0d_memory got=%0d differing words want=0", it, errs); end
    end
  endtask

`ifdef SUBLEQ_STEP_EN
  task automatic test_step();
    int n = 0;
    clear_mem();
    mem[0] = 8'd3; mem[1] = 8'd4; mem[2] = 8'd9; mem[3] = 8'd5; mem[4] = 8'd7;
    step = 1'b0;
    restart();
    for (int k = 0; k < 10; k++) begin
      tick();
      total++; if (load !== 1'b0 || store !== 1'b0) begin bad++; $display("FAIL st_wait%0d got=%b%b want=00", k, load, store); end
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (instr_done) n++;
      tick();
    end
    total++; if (n != 1) begin bad++; $display("FAIL st_count got=%0d want=1", n); end
    total++; if (load !== 1'b0 || pc !== 8'd3 || mem[4] !== 8'd2) begin bad++; $display("FAIL st_rest got=%b/%0d/%0d want=0/3/2", load, pc, mem[4]); end
    step = 1'b1;
  endtask
`endif

  initial begin
    clear_mem();
    test_reset();
    test_not_taken();
    test_taken();
    test_halt();
    test_wrap();
    test_reset_mid_write();
    test_random();
`ifdef SUBLEQ_STEP_EN
    test_step();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/subleq_sequencer.md
Name: subleq_sequencer

Overview:
- Initiator side of the word-addressed load/store memory interface; the SUBLEQ execution engine that drives the unified memory.
- Fetches the three-word instruction (A, B, C) at PC, then reads mem[A] and mem[B].
- Writes mem[B] - mem[A] back to B, then branches to C if the result is <= 0 (signed), else advances PC by 3.
- Sits between the top level and the memory block; this block owns all memory traffic.

Parameters:
- WORD_SIZE, 8: data and address width in bits; memory depth is 2^WORD_SIZE words.
- HALT_ADDR, 255: a taken branch to this address halts the core. Must fit in WORD_SIZE bits.

Ports:
- clk  input  1  system clock, rising edge.
- areset_n  input  1  asynchronous active-low reset.
- load  output  1  memory read strobe. Memory returns mem_out combinationally in the same cycle.
- store  output  1  memory write strobe. Memory captures mem_in at addr on the clk edge.
- addr  output  WORD_SIZE  memory address.
- mem_in  output  WORD_SIZE  write data to memory.
- mem_out  input  WORD_SIZE  read data from memory. Must be 0 when load=0.
- pc  output  WORD_SIZE  current program counter.
- halted  output  1  high once the halt condition has occurred; sticky until reset.
- instr_done  output  1  one-cycle pulse in the cycle an instruction retires (the WRITE cycle).

Interface (already decided):
- One clock; reset is asynchronous and active-low: clk, areset_n.

Behaviour:
- Reset (async, areset_n=0) takes effect immediately:
  - state=IDLE; pc, a, b, c, va, vb = 0.
  - load=0, store=0, addr=0, mem_in=0, halted=0, instr_done=0.
- State sequence: IDLE -> FETCH_A -> FETCH_B -> FETCH_C -> READ_A -> READ_B -> WRITE -> FETCH_A ..., or WRITE -> HALT.
- Each state lasts exactly 1 cycle, so an instruction takes 6 cycles after the single IDLE cycle.
- Per-state outputs and captures (latch = capture mem_out at end of cycle):
  - IDLE: load=0, store=0, addr=0.
  - FETCH_A: load=1, addr=pc; latch a.
  - FETCH_B: load=1, addr=pc+1; latch b.
  - FETCH_C: load=1, addr=pc+2; latch c.
  - READ_A: load=1, addr=a; latch va.
  - READ_B: load=1, addr=b; latch vb.
  - WRITE: store=1, load=0, addr=b, mem_in = diff = vb - va, instr_done=1.
- Strobe rules:
  - load and store are never high in the same cycle.
  - Outside WRITE, mem_in=0. Outside fetch/read states, load=0.
- Arithmetic: all address and data arithmetic is modulo 2^WORD_SIZE (pc+1, pc+2, pc+3 and diff wrap silently).
- Branch decision: taken if diff == 0 or diff[WORD_SIZE-1] == 1.
- PC update at the end of WRITE: next pc = c if taken, else pc+3.
- Halt: if taken and c == HALT_ADDR, go to HALT at the end of WRITE instead of FETCH_A.
  - The store in that WRITE cycle still occurs.
  - pc = HALT_ADDR.
  - In HALT: halted=1, load=0, store=0, addr=0; remains there until reset.
- Self-modifying code is allowed: a store to an address the next fetch reads is visible to that fetch, because the memory write completes at the WRITE edge.
- Reset asserted mid-instruction: outputs drop in the same instant with no clock needed; a pending WRITE never stores.

Optional Feature:
- Macro: SUBLEQ_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - After IDLE, and after each WRITE that does not halt, the core enters a WAIT state: load=0, store=0.
  - It leaves WAIT for FETCH_A on the first clk edge with step=1.
  - step is sampled only in WAIT; holding step high runs continuously with 7 cycles per instruction.
- Undefined: no step port and no WAIT state; 6 cycles per instruction.

Decomposition:
- Shared package/defines header holds:
  - WORD_SIZE default.
  - The state encoding localparams (IDLE, FETCH_A, FETCH_B, FETCH_C, READ_A, READ_B, WRITE, HALT, WAIT).
  - HALT_ADDR default.
- One natural sub-module: subleq_alu.
  - Combinational; inputs va, vb, pc, c.
  - Outputs diff, taken, next_pc.
  - Unit-testable alone.
- The FSM and registers remain in subleq_sequencer.

Test Plan (WORD_SIZE=8, paired with a memory model per the interface):
- mem[0..2]=3,4,9; mem[3]=5; mem[4]=7 -> on cycle 7 after reset release: store=1, addr=4, mem_in=2; not taken; pc=3.
- mem[0..2]=3,4,9; mem[3]=7; mem[4]=5 -> mem_in=0xFE, taken, pc=9; instr_done pulses exactly once per 6 cycles.
- mem[0..2]=3,3,255 -> mem[3] becomes 0, taken to HALT_ADDR; halted=1 and stays; load=store=0 for 20 further cycles.
- Program at pc=253, where mem[253..255] point to not-taken operands -> fetch addresses 253,254,255; next pc wraps to 0.
- Drive areset_n=0 asynchronously mid-WRITE -> store falls before the next edge; mem[B] unchanged; after release, restart from IDLE with pc=0.
- SUBLEQ_STEP_EN defined, step=0 -> core idles in WAIT with no load; one step pulse -> exactly one instruction retires and the core returns to WAIT.
